// File: rtl/bit_scatter_256.sv
// Indexed bit-deposit register: single-bit writes into a WIDTH-bit result, plus a
// burst mode that streams bits from a start index with an auto-incrementing, wrapping pointer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepts single-bit writes and burst starts
// BURST | one bit deposited per bit_valid beat until cnt reaches zero
module bit_scatter_256 #(
   parameter int WIDTH = 256,
   parameter int IDX_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   sel,
   input  logic               bit_in,
   input  logic               burst_start,
   input  logic [IDX_W:0]     burst_len,
   input  logic               bit_valid,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [WIDTH-1:0]   data_out
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic [IDX_W:0]   CNT_ZERO = '0;
   localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W:0]     cnt_q, cnt_d;
   logic               done_d;
   logic               err_d;
   logic               wr_fire;
   logic [IDX_W-1:0]   wr_idx;
   logic               wr_bit;

   // clr suppresses any deposit but leaves the sequencing (state, ptr, cnt) untouched,
   // so a beat that coincides with clr is simply not consumed.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wr_fire = 1'b0;
      wr_idx  = sel;
      wr_bit  = bit_in;

      case (state_q)
         IDLE: begin
            if (burst_start) begin
               if (burst_len == CNT_ZERO) begin
                  err_d = 1'b1;
               end else begin
                  state_d = BURST;
                  ptr_d   = sel;
                  cnt_d   = burst_len;
               end
            end else if (wr_en && !clr) begin
               wr_fire = 1'b1;
            end
         end

         BURST: begin
            if (bit_valid && !clr) begin
               wr_fire = 1'b1;
               wr_idx  = ptr_q;
               ptr_d   = ptr_q + PTR_ONE;
               cnt_d   = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         busy    <= (state_d == BURST);
         done    <= done_d;
         err     <= err_d;
         if (clr) begin
            data_out <= '0;
         end else if (wr_fire) begin
            data_out[wr_idx] <= wr_bit;
         end
      end
   end

endmodule
